zion_basic_circuit_lib_skid_reg: RTL and testbench
==================================================

# zion_basic_circuit_lib_skid_reg

Fully registered valid/ready register slice with a two-entry skid buffer. It is the handshake-aware counterpart of the library's enabled DFF: rather than taking an external enable, it derives its own load enables from the valid/ready protocol on both sides. It cuts every combinational path between the upstream producer and the downstream consumer (data, valid and ready) while sustaining one transfer per cycle. It sits between pipeline stages or at block boundaries that need timing closure.

## Interface
- WIDTH, 8, width of iDat/oDat in bits (>=1).
- INI_DATA, '0, reset value of the main and skid data registers.

- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- iFlush  input  1  synchronous flush; drops all buffered data.
- iVld  input  1  upstream data valid.
- oRdy  output  1  upstream ready; registered.
- iDat  input  WIDTH  upstream data.
- oVld  output  1  downstream data valid; registered.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH  downstream data; driven directly from the main register.
- oCnt  output  2  occupancy (0, 1 or 2); registered.

## Operation
- Upstream transfer (push) = iVld & oRdy. Downstream transfer (pop) = oVld & iRdy.
- Storage: main register (drives oDat) and skid register. There is no combinational path from any input to any output.
- States:
  - EMPTY: oVld=0, oCnt=0.
  - ONE: main valid, oVld=1, oCnt=1.
  - FULL: main and skid valid, oVld=1, oCnt=2.
- Transitions (iFlush=0):
  - EMPTY, push: main<=iDat, go to ONE.
  - ONE, push & pop: main<=iDat, stay in ONE.
  - ONE, push & !pop: skid<=iDat, go to FULL.
  - ONE, !push & pop: go to EMPTY; main holds its stale value.
  - FULL, pop: main<=skid, go to ONE. No push is possible because oRdy=0.
  - Any other combination: hold.
- oRdy next-state = (next state != FULL) & !rst. oRdy is registered.
- iFlush=1: next state is EMPTY; any push or pop in that cycle is discarded; data registers hold. iFlush has priority over every transition; rst has priority over iFlush.
- Reset state: EMPTY, oVld=0, oRdy=0, oCnt=0, oDat=INI_DATA, skid=INI_DATA. oRdy rises at the first posedge after rst deasserts.
- Downstream iRdy may toggle freely. The block never drops or duplicates data: the output order equals the push order.
- oDat is meaningful only when oVld=1.
- Protocol assumption checked by assertion in simulation: once iVld is raised with oRdy=0, iVld and iDat stay stable until a push occurs.

## Timing
- Latency: a push at edge N produces oVld=1 with that data after edge N (visible in cycle N+1).
- Throughput: 1 transfer/cycle sustained while iRdy=1.
- Backpressure: oRdy falls one cycle after iRdy first drops with the slice holding one entry. The skid register absorbs the single in-flight beat.
- Recovery: oRdy returns to 1 one cycle after the pop that leaves FULL.
- Asynchronous rst mid-transfer: outputs take their reset values immediately; in-flight data is lost.
- Boundary cases:
  - Simultaneous push & pop in ONE: occupancy unchanged.
  - Pop in FULL: skid moves to main in the same edge.
  - Flush in FULL: oRdy=1 after the edge.

## Test plan
- Reset then stream: hold rst 3 cycles, release; iVld=1 with iDat=1,2,3,… and iRdy=1 -> oRdy=0 during reset, 1 after the first edge; oDat=1,2,3 one per cycle, each one cycle after its push; oCnt stays 1.
- Backpressure: in ONE with data 5, push 6 while iRdy=0 -> FULL, oCnt=2, oRdy=0. Hold 4 cycles -> oDat=5 stable. Raise iRdy -> 5 then 6 delivered on consecutive cycles; oRdy back to 1.
- Random valid/ready: 10k cycles of random iVld/iRdy with an incrementing payload -> scoreboard confirms in-order delivery, no loss or duplication; oCnt matches the model each cycle.
- Flush: in FULL (data 0xA, 0xB), assert iFlush for 1 cycle with iVld=1, iDat=0xC -> next cycle oVld=0, oCnt=0, oRdy=1; 0xA, 0xB and 0xC never appear at the output.
- Async reset mid-stream: assert rst between clock edges while in FULL -> oVld=0, oRdy=0, oCnt=0, oDat=INI_DATA immediately, without waiting for a clock edge.
- WIDTH=1 and WIDTH=64 with INI_DATA nonzero -> reset oDat equals INI_DATA; the streaming test passes.

Source files
------------

// File: rtl/zion_basic_circuit_lib_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : zion_basic_circuit_lib_skid_reg
// Purpose  : Fully registered valid/ready register slice with a two-entry
//            skid buffer. It breaks every combinational path between the
//            producer and the consumer (data, valid and ready) and still
//            sustains one transfer per cycle.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            iFlush       - synchronous flush, drops all buffered entries
//            iVld/oRdy    - upstream handshake (oRdy registered)
//            iDat         - upstream data
//            oVld/iRdy    - downstream handshake (oVld registered)
//            oDat         - downstream data, straight from the main register
//            oCnt         - occupancy 0..2, registered
// Revision : 1.0 - initial release
// ============================================================================
module zion_basic_circuit_lib_skid_reg #(
    parameter int unsigned            WIDTH    = 8,
    parameter logic [WIDTH-1:0]       INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iFlush,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ordy_q,  ordy_d;
    logic             ovld_q,  ovld_d;
    logic [1:0]       cnt_q,   cnt_d;

    logic             w_push;
    logic             w_pop;

    // Handshakes use only registered outputs, so no input reaches an output
    // without passing through a flop.
    assign w_push = iVld & ordy_q;
    assign w_pop  = ovld_q & iRdy;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (iFlush) begin
            // Flush wins over any handshake; data registers simply hold.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        main_d  = iDat;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        main_d = iDat;
                    end else if (w_push) begin
                        // Consumer stalled: the in-flight beat lands in skid.
                        skid_d  = iDat;
                        state_d = ST_FULL;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // oRdy is low here, so only a pop can happen.
                    if (w_pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Output flags are computed from the next state so they can be
        // registered alongside it.
        ordy_d = (state_d != ST_FULL);
        ovld_d = (state_d != ST_EMPTY);
        case (state_d)
            ST_ONE:  cnt_d = 2'd1;
            ST_FULL: cnt_d = 2'd2;
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
            ordy_q  <= 1'b0;
            ovld_q  <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ordy_q  <= ordy_d;
            ovld_q  <= ovld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oRdy = ordy_q;
    assign oVld = ovld_q;
    assign oDat = main_q;
    assign oCnt = cnt_q;

`ifndef SYNTHESIS
    // A producer that has raised valid while we are not ready must keep
    // valid and data steady until the beat is taken (flush releases it).
    a_upstream_hold: assert property (@(posedge clk) disable iff (rst)
        (iVld && !oRdy && !iFlush) |=> (iVld && $stable(iDat)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_zion_basic_circuit_lib_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_zion_basic_circuit_lib_skid_reg
// Purpose  : Self-checking bench for the skid register slice. A queue model
//            tracks occupancy and delivery order; directed steps pin literal
//            values. Extra WIDTH=1 and WIDTH=64 instances run the same traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zion_basic_circuit_lib_skid_reg;

    localparam logic [7:0]  INI8  = 8'h5A;
    localparam logic        INI1  = 1'b1;
    localparam logic [63:0] INI64 = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst;
    logic        iFlush;
    logic        iVld;
    logic        iRdy;
    logic [7:0]  iDat;
    logic        oRdy, oVld;
    logic [7:0]  oDat;
    logic [1:0]  oCnt;

    logic        iDat1;
    logic [63:0] iDat64;
    logic        oRdy1, oVld1, oDat1;
    logic [1:0]  oCnt1;
    logic        oRdy64, oVld64;
    logic [63:0] oDat64;
    logic [1:0]  oCnt64;

    assign iDat1  = iDat[0];
    assign iDat64 = {8{iDat}};

    always #5 clk = ~clk;

    zion_basic_circuit_lib_skid_reg #(.WIDTH(8), .INI_DATA(INI8)) dut (
        .clk(clk), .rst(rst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy),
        .iDat(iDat), .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oCnt(oCnt));

    zion_basic_circuit_lib_skid_reg #(.WIDTH(1), .INI_DATA(INI1)) dut1 (
        .clk(clk), .rst(rst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy1),
        .iDat(iDat1), .oVld(oVld1), .iRdy(iRdy), .oDat(oDat1), .oCnt(oCnt1));

    zion_basic_circuit_lib_skid_reg #(.WIDTH(64), .INI_DATA(INI64)) dut64 (
        .clk(clk), .rst(rst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy64),
        .iDat(iDat64), .oVld(oVld64), .iRdy(iRdy), .oDat(oDat64), .oCnt(oCnt64));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most two beats -------
    logic [7:0] mq[$];
    bit         m_rdy = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit p_push, p_pop;
        if (rst) begin
            mq.delete();
            m_rdy = 1'b0;
        end else if (iFlush) begin
            mq.delete();
            m_rdy = 1'b1;
        end else begin
            p_push = iVld && m_rdy;
            p_pop  = (mq.size() != 0) && iRdy;
            if (p_pop)  void'(mq.pop_front());
            if (p_push) mq.push_back(iDat);
            m_rdy = (mq.size() < 2);
        end
    end

    // ---------------- per-cycle comparison against the model --------------
    always @(posedge clk) begin
        #1;
        chk("vld",    {63'd0, oVld},   {63'd0, mq.size() != 0});
        chk("rdy",    {63'd0, oRdy},   {63'd0, m_rdy});
        chk("cnt",    {62'd0, oCnt},   64'(mq.size()));
        chk("vld_w1", {63'd0, oVld1},  {63'd0, oVld});
        chk("cnt_w64",{62'd0, oCnt64}, 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("dat",     {56'd0, oDat},  {56'd0, mq[0]});
            chk("dat_w1",  {63'd0, oDat1}, {63'd0, mq[0][0]});
            chk("dat_w64", oDat64,         {8{mq[0]}});
        end
    end

    // Presents one beat at a negedge and holds it until accepted (bounded).
    task automatic push_one(input logic [7:0] d, input logic rdy);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        iVld = 1'b1;
        iDat = d;
        iRdy = rdy;
        for (int t = 0; t < 20; t++) begin
            acc = oRdy;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic will_push;
        logic [7:0] pay;

        rst = 1'b1; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",   {63'd0, oVld}, 64'd0);
        chk("rst_rdy",   {63'd0, oRdy}, 64'd0);
        chk("rst_cnt",   {62'd0, oCnt}, 64'd0);
        chk("rst_dat",   {56'd0, oDat}, 64'h5A);
        chk("rst_dat1",  {63'd0, oDat1}, 64'd1);
        chk("rst_dat64", oDat64, 64'hDEAD_BEEF_0123_4567);

        // Release; oRdy rises at the first edge afterwards.
        @(negedge clk);
        rst = 1'b0;
        iRdy = 1'b1;
        #1;
        chk("rdy_before_edge", {63'd0, oRdy}, 64'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", {63'd0, oRdy}, 64'd1);

        // Streaming: each beat appears right after its push, occupancy 1.
        for (int k = 1; k <= 5; k++) begin
            push_one(8'(k), 1'b1);
            chk("stream_dat", {56'd0, oDat}, 64'(k));
            chk("stream_cnt", {62'd0, oCnt}, 64'd1);
        end

        // Backpressure: 5 held, 6 pushed with iRdy low.
        push_one(8'h06, 1'b0);
        chk("bp_cnt", {62'd0, oCnt}, 64'd2);
        chk("bp_dat", {56'd0, oDat}, 64'h05);
        chk("bp_rdy", {63'd0, oRdy}, 64'd0);
        @(negedge clk);
        iVld = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {56'd0, oDat}, 64'h05);
        end
        @(negedge clk);
        iRdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_next_dat", {56'd0, oDat}, 64'h06);
        chk("bp_recover",  {63'd0, oRdy}, 64'd1);
        @(posedge clk);
        #1;
        chk("bp_drained", {63'd0, oVld}, 64'd0);

        // Flush while FULL, with a push and a pop offered in the same cycle.
        push_one(8'h0A, 1'b0);
        push_one(8'h0B, 1'b0);
        chk("fl_full", {62'd0, oCnt}, 64'd2);
        @(negedge clk);
        iVld = 1'b1; iDat = 8'h0C; iFlush = 1'b1; iRdy = 1'b1;
        @(posedge clk);
        #1;
        chk("fl_vld", {63'd0, oVld}, 64'd0);
        chk("fl_cnt", {62'd0, oCnt}, 64'd0);
        chk("fl_rdy", {63'd0, oRdy}, 64'd1);
        @(negedge clk);
        iFlush = 1'b0; iVld = 1'b0;
        repeat (3) @(posedge clk);
        push_one(8'h11, 1'b1);
        chk("fl_after", {56'd0, oDat}, 64'h11);
        @(negedge clk);
        iVld = 1'b0;
        repeat (2) @(posedge clk);

        // Random valid/ready traffic with an incrementing payload.
        will_push = 1'b0;
        pay = 8'h40;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (will_push) pay = pay + 8'd1;
            if (!(iVld && !will_push)) begin
                iVld = ($urandom_range(0, 3) != 0);
                iDat = pay;
            end
            iRdy = ($urandom_range(0, 2) != 0);
            will_push = iVld & oRdy;
        end
        @(negedge clk);
        iVld = 1'b0; iRdy = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset while FULL.
        push_one(8'h21, 1'b0);
        push_one(8'h22, 1'b0);
        @(negedge clk);
        iVld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld",   {63'd0, oVld}, 64'd0);
        chk("arst_rdy",   {63'd0, oRdy}, 64'd0);
        chk("arst_cnt",   {62'd0, oCnt}, 64'd0);
        chk("arst_dat",   {56'd0, oDat}, 64'h5A);
        chk("arst_dat1",  {63'd0, oDat1}, 64'd1);
        chk("arst_dat64", oDat64, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        iRdy = 1'b1;
        push_one(8'h31, 1'b1);
        chk("post_rst_dat",   {56'd0, oDat}, 64'h31);
        chk("post_rst_dat64", oDat64, 64'h3131_3131_3131_3131);
        @(negedge clk);
        iVld = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
